// File: rtl/pattern_search_pkg.sv
// rtl/pattern_search_pkg.sv - shared types, count widths and match rule for the pattern search engine
package pattern_search_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_t;

    function automatic int cb_width(input int pat_w, input int msg_bytes);
        return $clog2(msg_bytes * (9 - pat_w) + 1);
    endfunction

    function automatic int ch_width(input int msg_bytes);
        return $clog2(msg_bytes + 1);
    endfunction

    function automatic int cx_width(input int pat_w, input int msg_bytes);
        return $clog2(8 * msg_bytes - pat_w + 2);
    endfunction

    // Operands are zero-padded to 8 bits so one rule serves every pattern width.
    function automatic logic win_match(input logic [7:0] win, input logic [7:0] pat,
                                       input logic [7:0] mask);
        return ((win ^ pat) & mask) == 8'd0;
    endfunction

endpackage

// File: rtl/pattern_window_cmp.sv
// rtl/pattern_window_cmp.sv - counts in-byte and boundary window matches for one byte plus carried tail
module pattern_window_cmp
    import pattern_search_pkg::*;
#(
    parameter int PAT_W = 5
) (
    input  logic [PAT_W+6:0] bits,
    input  logic [PAT_W-1:0] pat,
    input  logic [PAT_W-1:0] mask,
    output logic [3:0]       in_cnt,
    output logic             any_hit,
    output logic [3:0]       bnd_cnt
);

    logic [7:0] w;
    logic [7:0] p;
    logic [7:0] m;

    // Window k covers bits[k+PAT_W-1:k]; k above 8-PAT_W reaches into the previous byte's tail.
    always_comb begin
        in_cnt  = '0;
        bnd_cnt = '0;
        w       = '0;
        p       = '0;
        m       = '0;
        p[PAT_W-1:0] = pat;
        m[PAT_W-1:0] = mask;
        for (int k = 0; k < 8; k++) begin
            w = '0;
            w[PAT_W-1:0] = bits[k +: PAT_W];
            if (win_match(w, p, m)) begin
                if (k <= 8 - PAT_W) in_cnt = in_cnt + 4'd1;
                else                bnd_cnt = bnd_cnt + 4'd1;
            end
        end
    end

    assign any_hit = (in_cnt != 4'd0);

endmodule

// File: rtl/pattern_search_engine.sv
// rtl/pattern_search_engine.sv - streams a message from data memory and counts masked pattern matches
module pattern_search_engine
    import pattern_search_pkg::*;
#(
    parameter int PAT_W     = 5,
    parameter int MSG_BYTES = 32,
    parameter int ADDR_W    = 8,
    parameter int BASE_ADDR = 0,
    localparam int CB_W     = cb_width(PAT_W, MSG_BYTES),
    localparam int CH_W     = ch_width(MSG_BYTES),
    localparam int CX_W     = cx_width(PAT_W, MSG_BYTES)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic [PAT_W-1:0]  pat,
    input  logic [PAT_W-1:0]  pat_mask,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_rd_addr,
    input  logic [7:0]        mem_rd_data,
    output logic              busy,
    output logic              done,
    output logic [CB_W-1:0]   cnt_byte,
    output logic [CH_W-1:0]   cnt_hit,
    output logic [CX_W-1:0]   cnt_cross
);

    localparam int IDX_W  = (MSG_BYTES > 1) ? $clog2(MSG_BYTES) : 1;
    localparam int TAIL_W = (PAT_W > 1) ? PAT_W - 1 : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MSG_BYTES - 1);

    state_t             state;
    logic [IDX_W-1:0]   idx_q;
    logic [PAT_W-1:0]   pat_q;
    logic [PAT_W-1:0]   mask_q;
    logic [TAIL_W-1:0]  tail_q;
    logic [7:0]         data_q;
    logic               rd_vld_q, rd_first_q, rd_last_q;
    logic               proc_vld_q, proc_first_q, proc_last_q;
    logic [PAT_W+6:0]   seg;
    logic [3:0]         in_cnt, bnd_cnt, bnd_eff, cross_inc;
    logic               any_hit;

    generate
        if (PAT_W > 1) begin : g_tail
            assign seg = {tail_q, data_q};
        end else begin : g_notail
            assign seg = data_q;
        end
    endgenerate

    pattern_window_cmp #(.PAT_W(PAT_W)) u_cmp (
        .bits    (seg),
        .pat     (pat_q),
        .mask    (mask_q),
        .in_cnt  (in_cnt),
        .any_hit (any_hit),
        .bnd_cnt (bnd_cnt)
    );

    // The first byte has no predecessor, so its boundary windows never count.
    assign bnd_eff     = proc_first_q ? 4'd0 : bnd_cnt;
    assign cross_inc   = in_cnt + bnd_eff;
    assign mem_rd_en   = (state == RUN);
    assign mem_rd_addr = ADDR_W'(BASE_ADDR) + ADDR_W'(idx_q);
    assign busy        = (state == RUN) || (state == FLUSH);
    assign done        = (state == DONE);

    // Pipeline: read issued (RUN) -> data returned (rd_*) -> data registered and accumulated (proc_*).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            idx_q        <= '0;
            pat_q        <= '0;
            mask_q       <= '0;
            tail_q       <= '0;
            data_q       <= '0;
            rd_vld_q     <= 1'b0;
            rd_first_q   <= 1'b0;
            rd_last_q    <= 1'b0;
            proc_vld_q   <= 1'b0;
            proc_first_q <= 1'b0;
            proc_last_q  <= 1'b0;
            cnt_byte     <= '0;
            cnt_hit      <= '0;
            cnt_cross    <= '0;
        end else begin
            rd_vld_q     <= (state == RUN);
            rd_first_q   <= (state == RUN) && (idx_q == '0);
            rd_last_q    <= (state == RUN) && (idx_q == LAST_IDX);
            proc_vld_q   <= rd_vld_q;
            proc_first_q <= rd_first_q;
            proc_last_q  <= rd_last_q;
            if (rd_vld_q) data_q <= mem_rd_data;

            case (state)
                IDLE, DONE: begin
                    if (req) begin
                        state     <= RUN;
                        idx_q     <= '0;
                        pat_q     <= pat;
                        mask_q    <= pat_mask;
                        tail_q    <= '0;
                        cnt_byte  <= '0;
                        cnt_hit   <= '0;
                        cnt_cross <= '0;
                    end
                end
                RUN: begin
                    if (idx_q == LAST_IDX) state <= FLUSH;
                    else                   idx_q <= idx_q + IDX_W'(1);
                end
                FLUSH: begin
                    if (proc_vld_q && proc_last_q) state <= DONE;
                end
                default: state <= IDLE;
            endcase

            if (proc_vld_q) begin
                cnt_byte  <= cnt_byte + CB_W'(in_cnt);
                cnt_hit   <= cnt_hit + CH_W'(any_hit);
                cnt_cross <= cnt_cross + CX_W'(cross_inc);
                tail_q    <= data_q[TAIL_W-1:0];
            end
        end
    end

endmodule
